ps2_scancode_ctrl: RTL and testbench

//   Sequences the PS/2 byte receiver (ps2_data_input) and turns its raw bytes into key events.
//   - Detects the frame start bit and pulses the receiver's start_receiving_data.
//   - Aborts frames that stall with a watchdog.
//   - Folds E0/F0 prefix bytes into one event: code, extended flag, release flag.
//   - Buffers events in a small FIFO with a valid/ready handshake for the Morse encoder.

---
 rtl/ps2_scancode_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ps2_scancode_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl
//   Sequences the PS/2 byte receiver and turns its raw bytes into key events.
//   A falling PS/2 clock edge with the data line low marks a frame start. The
//   receiver is kicked with a one-cycle start pulse and a watchdog runs until
//   a byte strobe arrives. E0/F0 prefix bytes are folded into a single
//   {code, extended, release} event. Events are queued in a small FIFO that
//   the consumer drains with a valid/ready handshake.
//
// Ports
//   i_clk                    system clock
//   i_rst                    synchronous active-high reset
//   i_ps2_clk_negedge        one-cycle pulse on a synchronised PS/2 clock fall
//   i_ps2_data               synchronised PS/2 data line
//   i_rx_data[7:0]           byte from the receiver
//   i_rx_data_strb           one-cycle byte-valid strobe from the receiver
//   o_start_receiving_data   one-cycle pulse: receiver begins a frame
//   o_rx_abort               one-cycle pulse: receiver must return to idle
//   o_key_code[7:0]          head event scan code, prefixes stripped
//   o_key_extended           head event was preceded by E0
//   o_key_release            head event was preceded by F0
//   o_key_valid              FIFO holds at least one event
//   i_key_ready              consumer takes the head when valid and ready
//   o_timeout_err            one-cycle pulse when the watchdog fires
//   o_overflow               sticky: an event was dropped on a full FIFO
module ps2_scancode_ctrl #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk_negedge,
    input  logic       i_ps2_data,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_data_strb,
    output logic       o_start_receiving_data,
    output logic       o_rx_abort,
    output logic [7:0] o_key_code,
    output logic       o_key_extended,
    output logic       o_key_release,
    output logic       o_key_valid,
    input  logic       i_key_ready,
    output logic       o_timeout_err,
    output logic       o_overflow
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RECEIVE
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_start;
    logic                 w_frameStart;
    logic                 w_timeout;

    logic                 r_ext;
    logic                 r_rel;
    logic                 r_pushValid;
    logic [9:0]           r_pushEntry;

    logic [9:0]           r_mem [FIFO_DEPTH];
    logic [PTR_W:0]       r_wrPtr;
    logic [PTR_W:0]       r_rdPtr;
    logic                 r_overflow;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    // Next-state logic. The watchdog abort is combinational so it lands in
    // the very cycle the timer reaches its last value; a strobe in that same
    // cycle suppresses it because the frame completed in time.
    always_comb begin
        w_nextState  = r_state;
        w_frameStart = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_ps2_clk_negedge && !i_ps2_data) begin
                    w_frameStart = 1'b1;
                    w_nextState  = RECEIVE;
                end
            end
            RECEIVE: begin
                if (i_rx_data_strb) begin
                    w_nextState = IDLE;
                end else if (r_timer == TIMER_LAST) begin
                    w_timeout   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register, watchdog timer and the registered start pulse, which
    // therefore coincides with the first RECEIVE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_start <= w_frameStart;
            if (w_frameStart) begin
                r_timer <= '0;
            end else if (r_state == RECEIVE) begin
                r_timer <= r_timer + TIMER_W'(1);
            end
        end
    end

    // Byte decode. Prefixes only set flags; a real code is staged for a push
    // one cycle later together with the flags that were pending when it
    // arrived. Keyboard error bytes and watchdog aborts discard prefixes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
            r_pushValid <= 1'b0;
            r_pushEntry <= '0;
        end else begin
            r_pushValid <= 1'b0;
            if (i_rx_data_strb) begin
                case (i_rx_data)
                    8'hE0: r_ext <= 1'b1;
                    8'hF0: r_rel <= 1'b1;
                    8'h00, 8'hFF: begin
                        r_ext <= 1'b0;
                        r_rel <= 1'b0;
                    end
                    default: begin
                        r_pushValid <= 1'b1;
                        r_pushEntry <= {i_rx_data, r_ext, r_rel};
                        r_ext       <= 1'b0;
                        r_rel       <= 1'b0;
                    end
                endcase
            end else if (w_timeout) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end
        end
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    // without a separate occupancy counter.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                     (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign w_pop   = !w_empty && i_key_ready;
    assign w_push  = r_pushValid && (!w_full || w_pop);

    // FIFO storage. A push into a full FIFO still succeeds when the head is
    // leaving in the same cycle; otherwise the event is dropped and the
    // sticky overflow flag records it. Storage is cleared on reset so the
    // head outputs read zero until the first event arrives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr[PTR_W-1:0]] <= r_pushEntry;
                r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
            end
            if (r_pushValid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_start_receiving_data = r_start;
    assign o_rx_abort             = w_timeout;
    assign o_timeout_err          = w_timeout;
    assign {o_key_code, o_key_extended, o_key_release} = r_mem[r_rdPtr[PTR_W-1:0]];
    assign o_key_valid            = !w_empty;
    assign o_overflow             = r_overflow;

endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// tb_ps2_scancode_ctrl
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A queue-based event model runs alongside and is compared with
//   the DUT on every falling clock edge.
module tb_ps2_scancode_ctrl;

    localparam int T = 40;
    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       neg;
    logic       ps2Data;
    logic [7:0] rxData;
    logic       strb;
    logic       ready;
    logic       startRx;
    logic       abortRx;
    logic [7:0] keyCode;
    logic       keyExt;
    logic       keyRel;
    logic       keyValid;
    logic       timeoutErr;
    logic       overflow;

    int nCompared;
    int nMismatched;

    ps2_scancode_ctrl #(
        .TIMEOUT_CYCLES(T),
        .FIFO_DEPTH(D)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_ps2_clk_negedge(neg),
        .i_ps2_data(ps2Data),
        .i_rx_data(rxData),
        .i_rx_data_strb(strb),
        .o_start_receiving_data(startRx),
        .o_rx_abort(abortRx),
        .o_key_code(keyCode),
        .o_key_extended(keyExt),
        .o_key_release(keyRel),
        .o_key_valid(keyValid),
        .i_key_ready(ready),
        .o_timeout_err(timeoutErr),
        .o_overflow(overflow)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by the model checker and directed checks.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then return pulses to idle.
    task automatic applyStimulus(input bit n, input bit d, input bit s,
                                 input logic [7:0] b, input bit r);
        neg     = n;
        ps2Data = d;
        strb    = s;
        rxData  = b;
        ready   = r;
        @(posedge clk);
        #1;
        neg     = 1'b0;
        ps2Data = 1'b1;
        strb    = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic idleCycle(input bit r);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, r);
    endtask

    task automatic strobeByte(input logic [7:0] b, input bit r);
        applyStimulus(1'b0, 1'b1, 1'b1, b, r);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        idleCycle(1'b0);
        rst = 1'b0;
    endtask

    // Behavioural model: frame tracking with an age counter, prefix flags,
    // a one-deep pending event and a queue standing in for the FIFO.
    bit         mLive;
    bit         mBusy;
    bit         mStart;
    bit         mExt;
    bit         mRel;
    bit         mPendValid;
    bit         mOverflow;
    bit         mFresh;
    bit         mPop;
    bit         mTimedOut;
    bit         expAbort;
    int         mAge;
    int         mSize;
    logic [9:0] mPend;
    logic [9:0] mHead;
    logic [9:0] mFifo[$];

    initial begin
        mLive = 1'b0;
        mFifo = {};
    end

    // Compare against the model mid-cycle, then advance the model with the
    // inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        if (mLive) begin
            expAbort = mBusy && !strb && (mAge == T - 1);
            checkOutput("start_receiving_data", startRx, mStart);
            checkOutput("rx_abort", abortRx, expAbort);
            checkOutput("timeout_err", timeoutErr, expAbort);
            checkOutput("key_valid", keyValid, mFifo.size() != 0);
            checkOutput("overflow", overflow, mOverflow);
            if (mFifo.size() != 0) begin
                mHead = mFifo[0];
                checkOutput("key_code", keyCode, mHead[9:2]);
                checkOutput("key_extended", keyExt, mHead[1]);
                checkOutput("key_release", keyRel, mHead[0]);
            end else if (mFresh) begin
                checkOutput("key_code_idle", keyCode, 0);
                checkOutput("key_extended_idle", keyExt, 0);
                checkOutput("key_release_idle", keyRel, 0);
            end
        end
        if (rst) begin
            mLive      = 1'b1;
            mBusy      = 1'b0;
            mStart     = 1'b0;
            mExt       = 1'b0;
            mRel       = 1'b0;
            mPendValid = 1'b0;
            mOverflow  = 1'b0;
            mFresh     = 1'b1;
            mAge       = 0;
            mFifo      = {};
        end else if (mLive) begin
            mSize = mFifo.size();
            mPop  = (mSize != 0) && ready;
            if (mPop) begin
                void'(mFifo.pop_front());
            end
            if (mPendValid) begin
                if (mSize < D || mPop) begin
                    mFifo.push_back(mPend);
                    mFresh = 1'b0;
                end else begin
                    mOverflow = 1'b1;
                end
            end
            mPendValid = 1'b0;
            mTimedOut  = 1'b0;
            mStart     = 1'b0;
            if (!mBusy) begin
                if (neg && !ps2Data) begin
                    mBusy  = 1'b1;
                    mAge   = 0;
                    mStart = 1'b1;
                end
            end else if (strb) begin
                mBusy = 1'b0;
            end else if (mAge == T - 1) begin
                mBusy     = 1'b0;
                mTimedOut = 1'b1;
            end else begin
                mAge++;
            end
            if (strb) begin
                case (rxData)
                    8'hE0: mExt = 1'b1;
                    8'hF0: mRel = 1'b1;
                    8'h00, 8'hFF: begin
                        mExt = 1'b0;
                        mRel = 1'b0;
                    end
                    default: begin
                        mPend      = {rxData, mExt, mRel};
                        mPendValid = 1'b1;
                        mExt       = 1'b0;
                        mRel       = 1'b0;
                    end
                endcase
            end else if (mTimedOut) begin
                mExt = 1'b0;
                mRel = 1'b0;
            end
        end
    end

    int         strbPct;
    int         pick;
    bit         rn;
    bit         rd;
    bit         rs;
    bit         rr;
    logic [7:0] rb;

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst     = 1'b1;
        neg     = 1'b0;
        ps2Data = 1'b1;
        strb    = 1'b0;
        rxData  = 8'h00;
        ready   = 1'b0;
        idleCycle(1'b0);
        idleCycle(1'b0);
        rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst start", startRx, 0);
        checkOutput("rst abort", abortRx, 0);
        checkOutput("rst valid", keyValid, 0);
        checkOutput("rst code", keyCode, 0);
        checkOutput("rst ext", keyExt, 0);
        checkOutput("rst rel", keyRel, 0);
        checkOutput("rst overflow", overflow, 0);
        checkOutput("rst terr", timeoutErr, 0);

        $display("[TB] frame start and plain key");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("start pulse", startRx, 1);
        idleCycle(1'b0);
        checkOutput("start single", startRx, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("no start in receive", startRx, 0);
        strobeByte(8'h1C, 1'b0);
        checkOutput("1C valid early", keyValid, 0);
        idleCycle(1'b0);
        checkOutput("1C valid", keyValid, 1);
        checkOutput("1C code", keyCode, 8'h1C);
        checkOutput("1C ext", keyExt, 0);
        checkOutput("1C rel", keyRel, 0);
        idleCycle(1'b1);
        checkOutput("1C popped", keyValid, 0);

        $display("[TB] extended break");
        strobeByte(8'hE0, 1'b0);
        strobeByte(8'hF0, 1'b0);
        checkOutput("prefix no event", keyValid, 0);
        strobeByte(8'h75, 1'b0);
        checkOutput("75 valid early", keyValid, 0);
        idleCycle(1'b0);
        checkOutput("75 valid", keyValid, 1);
        checkOutput("75 code", keyCode, 8'h75);
        checkOutput("75 ext", keyExt, 1);
        checkOutput("75 rel", keyRel, 1);
        idleCycle(1'b1);
        checkOutput("75 popped", keyValid, 0);

        $display("[TB] watchdog");
        strobeByte(8'hF0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("wd start", startRx, 1);
        for (int k = 1; k <= T - 2; k++) idleCycle(1'b0);
        checkOutput("wd abort early", abortRx, 0);
        idleCycle(1'b0);
        checkOutput("wd abort", abortRx, 1);
        checkOutput("wd terr", timeoutErr, 1);
        idleCycle(1'b0);
        checkOutput("wd abort single", abortRx, 0);
        strobeByte(8'h1C, 1'b0);
        idleCycle(1'b0);
        checkOutput("wd 1C valid", keyValid, 1);
        checkOutput("wd 1C rel cleared", keyRel, 0);
        idleCycle(1'b1);

        $display("[TB] overflow");
        for (int i = 0; i < 5; i++) strobeByte(8'h15 + 8'(i), 1'b0);
        idleCycle(1'b0);
        checkOutput("ovf flag", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ovf order", keyCode, 8'h15 + 8'(i));
            idleCycle(1'b1);
        end
        checkOutput("ovf drained", keyValid, 0);

        $display("[TB] push with pop while full");
        applyReset();
        checkOutput("rst2 overflow", overflow, 0);
        for (int i = 0; i < 4; i++) strobeByte(8'h21 + 8'(i), 1'b0);
        strobeByte(8'h25, 1'b0);
        idleCycle(1'b1);
        checkOutput("full push+pop overflow", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("full push+pop order", keyCode, 8'h22 + 8'(i));
            idleCycle(1'b1);
        end
        checkOutput("full push+pop drained", keyValid, 0);

        $display("[TB] reset mid-frame");
        strobeByte(8'h2A, 1'b0);
        idleCycle(1'b0);
        strobeByte(8'hE0, 1'b0);
        strobeByte(8'hF0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("pre-reset valid", keyValid, 1);
        applyReset();
        checkOutput("mid rst start", startRx, 0);
        checkOutput("mid rst valid", keyValid, 0);
        checkOutput("mid rst code", keyCode, 0);
        checkOutput("mid rst ext", keyExt, 0);
        checkOutput("mid rst rel", keyRel, 0);
        strobeByte(8'h1C, 1'b0);
        idleCycle(1'b0);
        checkOutput("stray 1C code", keyCode, 8'h1C);
        checkOutput("stray 1C ext", keyExt, 0);
        checkOutput("stray 1C rel", keyRel, 0);
        idleCycle(1'b1);

        $display("[TB] random traffic");
        for (int seg = 0; seg < 16; seg++) begin
            strbPct = (seg % 2 == 0) ? 30 : 2;
            for (int c = 0; c < 200; c++) begin
                rn   = ($urandom_range(0, 99) < 15);
                rd   = 1'($urandom_range(0, 1));
                rs   = ($urandom_range(0, 99) < strbPct);
                rr   = ($urandom_range(0, 99) < 40);
                pick = $urandom_range(0, 9);
                case (pick)
                    0: rb = 8'hE0;
                    1: rb = 8'hF0;
                    2: rb = 8'h00;
                    3: rb = 8'hFF;
                    default: rb = 8'($urandom_range(1, 254));
                endcase
                rst = ($urandom_range(0, 399) == 0);
                applyStimulus(rn, rd, rs, rb, rr);
                rst = 1'b0;
            end
        end
        idleCycle(1'b0);
        idleCycle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
